// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared 32-bit ALU.
// Issues one operation at a time, waits ALU_LAT cycles, and returns the captured result to the requester that owns it.
module alu_arbiter #(
    parameter int ALU_LAT = 1,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_flagin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_flagin,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp_result,
    output logic [3:0]   rsp_flags,
    output logic         rsp_err,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    output logic         alu_flagin,
    input  logic [W-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t       state;
    state_t       state_nx;
    logic         last_grant;
    logic         owner;
    logic         pend_err;
    logic [3:0]   cnt;
    logic         grant0;
    logic         grant1;
    logic         capture;
    logic [3:0]   sel_op;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic         sel_fi;
    logic         sel_ill;

    // Round-robin winner: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
    end

    // Mux the accepted requester's operation toward the ALU input registers.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        sel_fi = 1'b0;
        unique case (1'b1)
            req0_ready: begin
                sel_op = req0_op;
                sel_a  = req0_a;
                sel_b  = req0_b;
                sel_fi = req0_flagin;
            end
            req1_ready: begin
                sel_op = req1_op;
                sel_a  = req1_a;
                sel_b  = req1_b;
                sel_fi = req1_flagin;
            end
            default: ;
        endcase
        sel_ill = (sel_op > 4'h9);
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, handshake outputs and the result-capture strobe.
    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = 1'b1;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                busy       = 1'b0;
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 | grant1) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                rsp0_valid = ~owner;
                rsp1_valid = owner;
                if ((~owner & rsp0_ready) | (owner & rsp1_ready)) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Issue registers, latency counter, fairness/owner bits and the response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            pend_err   <= 1'b0;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            alu_flagin <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (req0_ready | req1_ready) begin
                alu_ctrl   <= sel_ill ? 4'h0 : sel_op;
                alu_a      <= sel_ill ? '0 : sel_a;
                alu_b      <= sel_ill ? '0 : sel_b;
                alu_flagin <= sel_fi;
                pend_err   <= sel_ill;
                owner      <= req1_ready;
                last_grant <= req1_ready;
                cnt        <= LAT_M1;
            end else if ((state == EXEC) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                rsp_result <= pend_err ? '0 : alu_result;
                rsp_flags  <= pend_err ? 4'b0000 : alu_flags;
                rsp_err    <= pend_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (ALU_LAT=1 and ALU_LAT=3) driven by a behavioural ALU.
// A transaction-level model is compared every cycle; directed steps pin literal values.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        v0 [2];
    logic        v1 [2];
    logic        rdy0 [2];
    logic        rdy1 [2];
    logic [3:0]  op0 [2];
    logic [3:0]  op1 [2];
    logic [31:0] a0 [2];
    logic [31:0] b0 [2];
    logic [31:0] a1 [2];
    logic [31:0] b1 [2];
    logic        fi0 [2];
    logic        fi1 [2];
    logic        rv0 [2];
    logic        rv1 [2];
    logic        rr0 [2];
    logic        rr1 [2];
    logic [31:0] res [2];
    logic [3:0]  flg [2];
    logic        err [2];
    logic [31:0] aa [2];
    logic [31:0] ab [2];
    logic [3:0]  actl [2];
    logic        afi [2];
    logic [31:0] ares [2];
    logic [3:0]  aflg [2];
    logic        busy [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // External ALU: returns {V,C,Z,N, result}.
    function automatic logic [35:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b, input logic fi);
        logic [32:0] s;
        logic [31:0] r;
        logic cy;
        logic v;
        s = '0; r = '0; cy = 1'b0; v = 1'b0;
        case (c)
            4'h0: begin
                s = {1'b0, a} + {1'b0, b} + {32'b0, fi};
                r = s[31:0]; cy = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'h1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; cy = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'h2: begin
                s = {1'b0, a} + 33'd1;
                r = s[31:0]; cy = s[32];
            end
            4'h3: begin
                r = a - 32'd1; cy = (a != 32'd0);
            end
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = a ^ b;
            4'h7: r = fi ? ~a : a;
            4'h8: begin r = {a[30:0], fi}; cy = a[31]; end
            4'h9: begin r = {fi, a[31:1]}; cy = a[0]; end
            default: r = '0;
        endcase
        return {v, cy, (r == 32'd0), r[31], r};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_arbiter #(.ALU_LAT(g == 0 ? 1 : 3), .W(32)) u_dut (
            .clk(clk), .rst(rst),
            .req0_valid(v0[g]), .req0_ready(rdy0[g]), .req0_op(op0[g]),
            .req0_a(a0[g]), .req0_b(b0[g]), .req0_flagin(fi0[g]),
            .req1_valid(v1[g]), .req1_ready(rdy1[g]), .req1_op(op1[g]),
            .req1_a(a1[g]), .req1_b(b1[g]), .req1_flagin(fi1[g]),
            .rsp0_valid(rv0[g]), .rsp0_ready(rr0[g]),
            .rsp1_valid(rv1[g]), .rsp1_ready(rr1[g]),
            .rsp_result(res[g]), .rsp_flags(flg[g]), .rsp_err(err[g]),
            .alu_a(aa[g]), .alu_b(ab[g]), .alu_ctrl(actl[g]), .alu_flagin(afi[g]),
            .alu_result(ares[g]), .alu_flags(aflg[g]), .busy(busy[g])
        );
        assign {aflg[g], ares[g]} = alu_fn(actl[g], aa[g], ab[g], afi[g]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Transaction model: one op in flight, timed by its age since the accept cycle.
    bit          m_busy [2];
    bit          m_lg [2];
    bit          m_own [2];
    bit          m_err [2];
    bit          m_perr [2];
    int          m_tacc [2];
    logic [31:0] m_aa [2];
    logic [31:0] m_ab [2];
    logic [3:0]  m_actl [2];
    logic        m_afi [2];
    logic [31:0] m_res [2];
    logic [31:0] m_pres [2];
    logic [3:0]  m_flg [2];
    logic [3:0]  m_pflg [2];
    logic [3:0]  t_op;
    logic [31:0] t_a;
    logic [31:0] t_b;
    logic        t_fi;
    logic        t_ill;
    int          age;
    bit          inresp;
    bit          w0;
    bit          w1;

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] = 0; m_lg[d] = 1; m_own[d] = 0; m_err[d] = 0; m_perr[d] = 0;
                m_tacc[d] = 0; m_aa[d] = 0; m_ab[d] = 0; m_actl[d] = 0; m_afi[d] = 0;
                m_res[d] = 0; m_pres[d] = 0; m_flg[d] = 0; m_pflg[d] = 0;
            end else begin
                age    = cyc - m_tacc[d];
                inresp = m_busy[d] && (age > lat(d));
                w0 = !m_busy[d] && v0[d] && (!v1[d] || m_lg[d]);
                w1 = !m_busy[d] && v1[d] && (!v0[d] || !m_lg[d]);
                chk($sformatf("m%0d_rdy0", d), rdy0[d], w0);
                chk($sformatf("m%0d_rdy1", d), rdy1[d], w1);
                chk($sformatf("m%0d_busy", d), busy[d], m_busy[d]);
                chk($sformatf("m%0d_rv0", d), rv0[d], inresp && !m_own[d]);
                chk($sformatf("m%0d_rv1", d), rv1[d], inresp && m_own[d]);
                chk($sformatf("m%0d_alu_a", d), aa[d], m_aa[d]);
                chk($sformatf("m%0d_alu_b", d), ab[d], m_ab[d]);
                chk($sformatf("m%0d_alu_ctrl", d), actl[d], m_actl[d]);
                chk($sformatf("m%0d_alu_fi", d), afi[d], m_afi[d]);
                chk($sformatf("m%0d_res", d), res[d], m_res[d]);
                chk($sformatf("m%0d_flags", d), flg[d], m_flg[d]);
                chk($sformatf("m%0d_err", d), err[d], m_err[d]);
                if (w0 || w1) begin
                    t_op  = w1 ? op1[d] : op0[d];
                    t_a   = w1 ? a1[d] : a0[d];
                    t_b   = w1 ? b1[d] : b0[d];
                    t_fi  = w1 ? fi1[d] : fi0[d];
                    t_ill = (t_op > 4'h9);
                    m_actl[d] = t_ill ? 4'h0 : t_op;
                    m_aa[d]   = t_ill ? 32'd0 : t_a;
                    m_ab[d]   = t_ill ? 32'd0 : t_b;
                    m_afi[d]  = t_fi;
                    m_perr[d] = t_ill;
                    {m_pflg[d], m_pres[d]} = t_ill ? 36'd0 : alu_fn(t_op, t_a, t_b, t_fi);
                    m_own[d]  = w1;
                    m_lg[d]   = w1;
                    m_busy[d] = 1;
                    m_tacc[d] = cyc;
                end else if (m_busy[d] && age == lat(d)) begin
                    m_res[d] = m_pres[d];
                    m_flg[d] = m_pflg[d];
                    m_err[d] = m_perr[d];
                end else if (inresp && (m_own[d] ? rr1[d] : rr0[d])) begin
                    m_busy[d] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit sig(input int d, input int code);
        case (code)
            0: return rdy0[d];
            1: return rdy1[d];
            2: return rv0[d];
            3: return rv1[d];
            4: return !busy[d];
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int d, input int code);
        int n;
        n = 0;
        @(negedge clk);
        while (!sig(d, code) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!sig(d, code)) begin
            checks++;
            failures++;
            $display("FAIL %s timeout got=0 want=1", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int n;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            v0[d] = 0; v1[d] = 0; op0[d] = 0; op1[d] = 0;
            a0[d] = 0; b0[d] = 0; a1[d] = 0; b1[d] = 0;
            fi0[d] = 0; fi1[d] = 0; rr0[d] = 1; rr1[d] = 1;
        end
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy[0], 0);
        chk("rst_res", res[0], 0);
        chk("rst_ctrl", actl[1], 0);
        chk("rst_rv", {rv0[0], rv1[0]}, 0);

        // add 5+7 with single-cycle latency
        tick();
        v0[0] = 1; op0[0] = 4'h0; a0[0] = 5; b0[0] = 7; fi0[0] = 0;
        @(negedge clk);
        chk("t1_rdy0", rdy0[0], 1);
        chk("t1_rdy1", rdy1[0], 0);
        tick();
        v0[0] = 0; a0[0] = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("t1_exec_rv0", rv0[0], 0);
        chk("t1_exec_a", aa[0], 5);
        @(negedge clk);
        chk("t1_rv0", rv0[0], 1);
        chk("t1_res", res[0], 12);
        chk("t1_flags", flg[0], 4'b0000);
        chk("t1_rv1", rv1[0], 0);
        tick();

        // fresh reset so the tie sequence starts at requester 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        v0[0] = 1; v1[0] = 1;
        op0[0] = 4'h1; a0[0] = 3; b0[0] = 3;
        op1[0] = 4'h1; a1[0] = 3; b1[0] = 3;
        g = 0;
        n = 0;
        while (g < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (rv0[0] | rv1[0]) begin
                chk("t2_res", res[0], 0);
                chk("t2_z", flg[0][1], 1);
            end
            if (rdy0[0] | rdy1[0]) begin
                chk("t2_grant", rdy1[0], g % 2);
                g++;
            end
        end
        chk("t2_grants", g, 4);
        tick();
        v0[0] = 0; v1[0] = 0;
        wait_for("t2_idle", 0, 4);

        // back-pressure on requester 1
        tick();
        v1[0] = 1; op1[0] = 4'h4; a1[0] = 32'hF0F0_F0F0; b1[0] = 32'h0FF0_0FF0;
        fi1[0] = 0; rr1[0] = 0;
        wait_for("t3_acc", 0, 1);
        tick();
        v1[0] = 0; a1[0] = 0; b1[0] = 0;
        v0[0] = 1; op0[0] = 4'h0; a0[0] = 1; b0[0] = 2; fi0[0] = 0;
        wait_for("t3_rsp", 0, 3);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("t3_rv1", rv1[0], 1);
            chk("t3_res", res[0], 32'h00F0_00F0);
            chk("t3_rdy0", rdy0[0], 0);
        end
        tick();
        rr1[0] = 1;
        @(negedge clk);
        chk("t3_hs_rdy0", rdy0[0], 0);
        @(negedge clk);
        chk("t3_next_rdy0", rdy0[0], 1);
        tick();
        v0[0] = 0;
        wait_for("t3_idle", 0, 4);

        // illegal opcode
        tick();
        v0[0] = 1; op0[0] = 4'hC; a0[0] = 1; b0[0] = 1;
        wait_for("t4_acc", 0, 0);
        tick();
        v0[0] = 0;
        @(negedge clk);
        chk("t4_ctrl", actl[0], 4'h0);
        chk("t4_a", aa[0], 0);
        chk("t4_busy", busy[0], 1);
        @(negedge clk);
        chk("t4_rv0", rv0[0], 1);
        chk("t4_err", err[0], 1);
        chk("t4_res", res[0], 0);
        chk("t4_flags", flg[0], 4'b0000);
        wait_for("t4_idle", 0, 4);

        // three-cycle latency instance
        tick();
        v0[1] = 1; op0[1] = 4'h2; a0[1] = 32'hFFFF_FFFF; b0[1] = 0; fi0[1] = 0;
        @(negedge clk);
        chk("t5_rdy0", rdy0[1], 1);
        tick();
        v0[1] = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("t5_hold_a", aa[1], 32'hFFFF_FFFF);
            chk("t5_hold_ctrl", actl[1], 4'h2);
            chk("t5_rv0_low", rv0[1], 0);
        end
        @(negedge clk);
        chk("t5_rv0", rv0[1], 1);
        chk("t5_res", res[1], 0);
        chk("t5_c", flg[1][2], 1);
        wait_for("t5_idle", 1, 4);

        // reset while requester 1's op executes
        tick();
        v1[0] = 1; op1[0] = 4'h0; a1[0] = 1; b1[0] = 1;
        wait_for("t6_acc", 0, 1);
        tick();
        v1[0] = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_exec_busy", busy[0], 1);
        tick();
        rst = 1'b0;
        v0[0] = 1; v1[0] = 1;
        op0[0] = 4'h0; a0[0] = 2; b0[0] = 2;
        op1[0] = 4'h0; a1[0] = 2; b1[0] = 2;
        @(negedge clk);
        chk("t6_busy", busy[0], 0);
        chk("t6_rv0", rv0[0], 0);
        chk("t6_rv1", rv1[0], 0);
        chk("t6_tie0", rdy0[0], 1);
        chk("t6_tie1", rdy1[0], 0);
        tick();
        v0[0] = 0; v1[0] = 0;
        wait_for("t6_idle", 0, 4);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
